// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    // Architectural zero register address.
    localparam int unsigned REG_ZERO = 0;

    // Default configuration.
    localparam int unsigned DEF_REG_WIDTH = 64;
    localparam int unsigned DEF_NUM_REGS  = 32;
    localparam int unsigned DEF_NUM_RD    = 2;
    localparam int unsigned DEF_NUM_WR    = 1;

    // Upper bound on write ports; narrower configs pad the unused port with wr_en = 0.
    localparam int unsigned MAX_WR = 2;

    typedef struct packed {
        logic valid;
        logic idx;
    } wr_sel_t;

    // Pick the winning write port among those hitting one register: port 1 beats port 0.
    function automatic wr_sel_t prio_sel(input logic [MAX_WR-1:0] hit);
        wr_sel_t s;
        s.valid = |hit;
        s.idx   = hit[1];
        return s;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: alloc sets, write clears, alloc wins over a same-cycle write.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned NUM_WR   = DEF_NUM_WR,
    parameter int unsigned FORWARD  = 1,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] rs_addr,
    output logic [NUM_RD-1:0]    rs_busy,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_rd
);

    logic [MAX_WR-1:0] we;
    logic [AW-1:0]     wa [MAX_WR];

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] clr;
    logic [NUM_REGS-1:0] set;

    for (genvar j = 0; j < MAX_WR; j++) begin : g_wpad
        if (j < NUM_WR) begin : g_used
            assign we[j] = wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO));
            assign wa[j] = wr_addr[j*AW +: AW];
        end else begin : g_unused
            assign we[j] = 1'b0;
            assign wa[j] = '0;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign clr[r]    = 1'b0;
            assign set[r]    = 1'b0;
            assign busy_d[r] = 1'b0;
        end else begin : g_live
            assign clr[r] = (we[0] && (wa[0] == AW'(r))) || (we[1] && (wa[1] == AW'(r)));
            assign set[r] = alloc_en && (alloc_rd == AW'(r));
            // A newer producer allocated this cycle keeps the register busy.
            assign busy_d[r] = set[r] | (busy_q[r] & ~clr[r]);
        end
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Busy lookup; with forwarding a same-cycle write masks busy unless re-allocated.
    always_comb begin
        rs_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (FORWARD != 0) begin
                rs_busy[i] = busy_q[rs_addr[i*AW +: AW]]
                             & ~(clr[rs_addr[i*AW +: AW]] & ~set[rs_addr[i*AW +: AW]]);
            end else begin
                rs_busy[i] = busy_q[rs_addr[i*AW +: AW]];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired x0, optional write forwarding and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned REG_WIDTH = DEF_REG_WIDTH,
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
    parameter int unsigned NUM_RD    = DEF_NUM_RD,
    parameter int unsigned NUM_WR    = DEF_NUM_WR,
    parameter int unsigned FORWARD   = 1,
    parameter int unsigned AW        = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_RD*AW-1:0]        rs_addr,
    output logic [NUM_RD*REG_WIDTH-1:0] rs_dout,
    output logic [NUM_RD-1:0]           rs_busy,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*AW-1:0]        wr_addr,
    input  logic [NUM_WR*REG_WIDTH-1:0] wr_data,
    input  logic                        alloc_en,
    input  logic [AW-1:0]               alloc_rd
);

    logic [MAX_WR-1:0]    we;
    logic [AW-1:0]        wa [MAX_WR];
    logic [REG_WIDTH-1:0] wd [MAX_WR];

    logic [REG_WIDTH-1:0] mem_q [NUM_REGS];
    logic [REG_WIDTH-1:0] mem_d [NUM_REGS];

    // Writes to x0 are dropped here so neither storage nor forwarding ever sees them.
    for (genvar j = 0; j < MAX_WR; j++) begin : g_wpad
        if (j < NUM_WR) begin : g_used
            assign we[j] = wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO));
            assign wa[j] = wr_addr[j*AW +: AW];
            assign wd[j] = wr_data[j*REG_WIDTH +: REG_WIDTH];
        end else begin : g_unused
            assign we[j] = 1'b0;
            assign wa[j] = '0;
            assign wd[j] = '0;
        end
    end

    // Write decode: each register takes the highest-priority hitting port.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign mem_d[r] = '0;
        end else begin : g_live
            logic [MAX_WR-1:0] whit;
            wr_sel_t           ws;
            assign whit = {we[1] && (wa[1] == AW'(r)), we[0] && (wa[0] == AW'(r))};
            assign ws   = prio_sel(whit);
            assign mem_d[r] = ws.valid ? wd[ws.idx] : mem_q[r];
        end
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    // Read ports with optional same-cycle bypass of write data.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [MAX_WR-1:0] rhit;
        wr_sel_t           fs;
        assign ra   = rs_addr[i*AW +: AW];
        assign rhit = {we[1] && (wa[1] == ra), we[0] && (wa[0] == ra)};
        assign fs   = prio_sel(rhit);

        // Bypass is suppressed while in reset so outputs read zero.
        always_comb begin
            if (ra == AW'(REG_ZERO)) begin
                rs_dout[i*REG_WIDTH +: REG_WIDTH] = '0;
            end else if ((FORWARD != 0) && rst_n && fs.valid) begin
                rs_dout[i*REG_WIDTH +: REG_WIDTH] = wd[fs.idx];
            end else begin
                rs_dout[i*REG_WIDTH +: REG_WIDTH] = mem_q[ra];
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .FORWARD  (FORWARD),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rs_busy  (rs_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .alloc_en (alloc_en),
        .alloc_rd (alloc_rd)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: forwarding and non-forwarding instances share stimulus and a reference model.
module tb_regfile_mp;

    localparam int RW  = 64;
    localparam int NR  = 32;
    localparam int NRD = 4;
    localparam int NWR = 2;
    localparam int AWT = 5;

    logic clk = 1'b0;
    logic rst_n;

    logic [AWT-1:0] ra [NRD];
    logic           we_t [NWR];
    logic [AWT-1:0] wa_t [NWR];
    logic [RW-1:0]  wd_t [NWR];
    logic           alloc_en;
    logic [AWT-1:0] alloc_rd;

    logic [NRD*AWT-1:0] rs_addr;
    logic [NWR-1:0]     wr_en;
    logic [NWR*AWT-1:0] wr_addr;
    logic [NWR*RW-1:0]  wr_data;
    logic [NRD*RW-1:0]  dout_f, dout_n;
    logic [NRD-1:0]     busy_f, busy_n;

    for (genvar i = 0; i < NRD; i++) begin : g_pk_rd
        assign rs_addr[i*AWT +: AWT] = ra[i];
    end
    for (genvar j = 0; j < NWR; j++) begin : g_pk_wr
        assign wr_en[j]              = we_t[j];
        assign wr_addr[j*AWT +: AWT] = wa_t[j];
        assign wr_data[j*RW +: RW]   = wd_t[j];
    end

    regfile_mp #(
        .REG_WIDTH (RW), .NUM_REGS (NR), .NUM_RD (NRD), .NUM_WR (NWR), .FORWARD (1)
    ) dut_f (
        .clk (clk), .rst_n (rst_n), .rs_addr (rs_addr), .rs_dout (dout_f), .rs_busy (busy_f),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .alloc_en (alloc_en), .alloc_rd (alloc_rd)
    );

    regfile_mp #(
        .REG_WIDTH (RW), .NUM_REGS (NR), .NUM_RD (NRD), .NUM_WR (NWR), .FORWARD (0)
    ) dut_n (
        .clk (clk), .rst_n (rst_n), .rs_addr (rs_addr), .rs_dout (dout_n), .rs_busy (busy_n),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .alloc_en (alloc_en), .alloc_rd (alloc_rd)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents and pending-producer flags.
    logic [RW-1:0] m_mem  [NR];
    bit            m_busy [NR];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Later ports overwrite earlier ones; allocation is applied last so it wins.
    task automatic model_update();
        for (int j = 0; j < NWR; j++) begin
            if (we_t[j] && wa_t[j] != 0) begin
                m_mem[wa_t[j]]  = wd_t[j];
                m_busy[wa_t[j]] = 1'b0;
            end
        end
        if (alloc_en && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
    endtask

    function automatic logic [RW-1:0] exp_dout(input int i, input bit fwd);
        if (!rst_n || ra[i] == 0) return '0;
        if (fwd) begin
            for (int j = NWR - 1; j >= 0; j--) begin
                if (we_t[j] && wa_t[j] == ra[i]) return wd_t[j];
            end
        end
        return m_mem[ra[i]];
    endfunction

    function automatic logic [RW-1:0] exp_busy(input int i, input bit fwd);
        bit b, written, realloc;
        if (ra[i] == 0) return '0;
        b = m_busy[ra[i]];
        written = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (we_t[j] && wa_t[j] == ra[i]) written = 1'b1;
        end
        realloc = alloc_en && (alloc_rd == ra[i]);
        if (fwd && written && !realloc) b = 1'b0;
        return {63'd0, b};
    endfunction

    task automatic check_all();
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("dout_f[%0d]", i), dout_f[i*RW +: RW], exp_dout(i, 1'b1));
            chk($sformatf("dout_n[%0d]", i), dout_n[i*RW +: RW], exp_dout(i, 1'b0));
            chk($sformatf("busy_f[%0d]", i), {63'd0, busy_f[i]}, exp_busy(i, 1'b1));
            chk($sformatf("busy_n[%0d]", i), {63'd0, busy_n[i]}, exp_busy(i, 1'b0));
        end
    endtask

    task automatic idle();
        for (int i = 0; i < NRD; i++) ra[i] = '0;
        for (int j = 0; j < NWR; j++) begin
            we_t[j] = 1'b0;
            wa_t[j] = '0;
            wd_t[j] = '0;
        end
        alloc_en = 1'b0;
        alloc_rd = '0;
    endtask

    task automatic set_wr(input int j, input logic [AWT-1:0] a, input logic [RW-1:0] d);
        we_t[j] = 1'b1;
        wa_t[j] = a;
        wd_t[j] = d;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    function automatic logic [AWT-1:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return AWT'(NR - 1);
            2:       return AWT'($urandom_range(1, 3));
            default: return AWT'($urandom_range(0, NR - 1));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        settle();
        check_all();
        rst_n = 1'b1;

        // x5 = 0xDEAD, alloc x6; then an asynchronous reset pulse between edges.
        idle();
        set_wr(0, 5, 64'hDEAD);
        alloc_en = 1'b1;
        alloc_rd = 6;
        settle();
        check_all();
        clock_edge();
        idle();
        ra[0] = 5;
        ra[1] = 6;
        settle();
        chk("x5_written", dout_f[0 +: RW], 64'hDEAD);
        chk("x6_busy", {63'd0, busy_f[1]}, 64'd1);
        check_all();
        rst_n = 1'b0;
        model_reset();
        settle();
        chk("rst_x5_f", dout_f[0 +: RW], 64'd0);
        chk("rst_x5_n", dout_n[0 +: RW], 64'd0);
        chk("rst_busy_f", {60'd0, busy_f}, 64'd0);
        chk("rst_busy_n", {60'd0, busy_n}, 64'd0);
        check_all();
        rst_n = 1'b1;
        settle();
        clock_edge();

        // x0 is immune to writes and allocation.
        idle();
        set_wr(0, 0, '1);
        set_wr(1, 0, '1);
        alloc_en = 1'b1;
        alloc_rd = 0;
        settle();
        chk("x0_wcyc", dout_f[0 +: RW], 64'd0);
        chk("x0_busy_wcyc", {63'd0, busy_f[0]}, 64'd0);
        check_all();
        clock_edge();
        idle();
        settle();
        chk("x0_next", dout_f[0 +: RW], 64'd0);
        chk("x0_busy_next", {63'd0, busy_f[0]}, 64'd0);
        check_all();

        // Same-cycle forwarding versus stored value.
        set_wr(0, 3, 64'h1111);
        settle();
        check_all();
        clock_edge();
        idle();
        set_wr(0, 3, 64'h1234);
        ra[0] = 3;
        settle();
        chk("fwd_x3", dout_f[0 +: RW], 64'h1234);
        chk("nofwd_x3_old", dout_n[0 +: RW], 64'h1111);
        check_all();
        clock_edge();
        idle();
        ra[0] = 3;
        settle();
        chk("nofwd_x3_new", dout_n[0 +: RW], 64'h1234);
        check_all();

        // Dual-write conflict: port 1 wins.
        idle();
        set_wr(0, 7, 64'hA);
        set_wr(1, 7, 64'hB);
        ra[0] = 7;
        settle();
        chk("conf_fwd", dout_f[0 +: RW], 64'hB);
        check_all();
        clock_edge();
        idle();
        ra[0] = 7;
        settle();
        chk("conf_f", dout_f[0 +: RW], 64'hB);
        chk("conf_n", dout_n[0 +: RW], 64'hB);
        check_all();

        // Scoreboard: alloc, write-clear, alloc+write.
        idle();
        alloc_en = 1'b1;
        alloc_rd = 9;
        ra[1] = 9;
        settle();
        chk("sb_alloc_same", {63'd0, busy_f[1]}, 64'd0);
        check_all();
        clock_edge();
        idle();
        ra[1] = 9;
        settle();
        chk("sb_busy_f", {63'd0, busy_f[1]}, 64'd1);
        chk("sb_busy_n", {63'd0, busy_n[1]}, 64'd1);
        check_all();
        set_wr(0, 9, 64'h55);
        settle();
        chk("sb_wr_busy_f", {63'd0, busy_f[1]}, 64'd0);
        chk("sb_wr_dout_f", dout_f[RW +: RW], 64'h55);
        chk("sb_wr_busy_n", {63'd0, busy_n[1]}, 64'd1);
        check_all();
        clock_edge();
        idle();
        ra[1] = 9;
        settle();
        chk("sb_cleared", {63'd0, busy_n[1]}, 64'd0);
        check_all();
        set_wr(0, 9, 64'h66);
        alloc_en = 1'b1;
        alloc_rd = 9;
        settle();
        check_all();
        clock_edge();
        idle();
        ra[1] = 9;
        settle();
        chk("sb_alloc_wr", {63'd0, busy_f[1]}, 64'd1);
        check_all();

        // Randomized sweep.
        for (int c = 0; c < 10000; c++) begin
            idle();
            for (int j = 0; j < NWR; j++) begin
                we_t[j] = 1'($urandom_range(0, 1));
                wa_t[j] = rand_addr();
                wd_t[j] = {$urandom, $urandom};
            end
            alloc_en = 1'($urandom_range(0, 1));
            alloc_rd = rand_addr();
            for (int i = 0; i < NRD; i++) begin
                case ($urandom_range(0, 3))
                    0:       ra[i] = wa_t[0];
                    1:       ra[i] = wa_t[1];
                    default: ra[i] = rand_addr();
                endcase
            end
            settle();
            check_all();
            clock_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
